ps2_host_tx: RTL and testbench

Host-to-device transmitter for the board PS/2 port, the complement of the keyboard/mouse scan-code receiver path. Accepts one byte per valid/ready handshake, performs the PS/2 request-to-send sequence, and shifts the byte, odd parity and stop bit out on device-generated clocks. It then checks the device acknowledge bit. It sits beside the PS/2 receiver in the top level. It drives `PS2_CLK`/`PS2_DAT` through open-drain enables: the top level assigns low when an enable is set, high-Z otherwise. Typical use is sending keyboard commands such as 0xED set-LEDs, with the LED state taken from `SW`.

---
 rtl/ps2_pkg.sv | 8 +
 rtl/ps2_sync_edge.sv | 17 +
 rtl/ps2_host_tx.sv | 128 ++++++++++++
 tb/tb_ps2_host_tx.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 host transmitter types and constants
package ps2_pkg;
    typedef enum logic [2:0] {IDLE, INHIBIT, START, SHIFT, ACK, WAIT_IDLE} state_t;
    localparam int FRAME_BITS = 10;
    localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] PS2_CMD_ECHO     = 8'hEE;
    localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
endpackage

// File: rtl/ps2_sync_edge.sv
// ps2_sync_edge: 2-flop synchronizer with falling-edge detect, idles high
module ps2_sync_edge (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_pin,
    output logic o_sync,
    output logic o_fall
);
    logic r_meta, r_sync, r_hist;
    // resync the pin and keep one cycle of history for edge detection
    always_ff @(posedge i_clk) begin
        if (i_rst) {r_meta, r_sync, r_hist} <= 3'b111;
        else {r_meta, r_sync, r_hist} <= {i_pin, r_meta, r_sync};
    end
    assign o_sync = r_sync;
    assign o_fall = r_hist & ~r_sync;
endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device byte transmitter with ack check and watchdog
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic       CLOCK_50,
    input  logic       RESET,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_error,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe
);
    localparam int CNT_MAX = INHIBIT_CYCLES > TIMEOUT_CYCLES ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CW = $clog2(CNT_MAX + 1);
    state_t      r_state;
    logic [CW-1:0] r_cnt;
    logic [3:0]  r_idx;
    logic [7:0]  r_data;
    logic        r_parity, r_ackbad;
    logic        r_ready, r_done, r_error, r_clk_oe, r_dat_oe;
    logic [1:0]  r_dat_sync;
    logic        w_clk_sync, w_clk_fall, w_dat_sync, w_timeout, w_inhibit_end;
    logic [9:0]  w_frame;

    ps2_sync_edge u_clk_sync (
        .i_clk (CLOCK_50),
        .i_rst (RESET),
        .i_pin (ps2_clk_in),
        .o_sync(w_clk_sync),
        .o_fall(w_clk_fall)
    );

    // data pin only needs resynchronizing, never edge detection
    always_ff @(posedge CLOCK_50) begin
        if (RESET) r_dat_sync <= 2'b11;
        else r_dat_sync <= {r_dat_sync[0], ps2_dat_in};
    end

    assign w_dat_sync    = r_dat_sync[1];
    assign w_frame       = {1'b1, r_parity, r_data};
    assign w_timeout     = r_cnt == CW'(TIMEOUT_CYCLES - 1);
    assign w_inhibit_end = r_cnt == CW'(INHIBIT_CYCLES - 2);

    // transmit sequencer; the START cycle is the last cycle of the clock inhibit
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_idx    <= '0;
            r_data   <= '0;
            r_parity <= 1'b0;
            r_ackbad <= 1'b0;
            r_ready  <= 1'b1;
            r_done   <= 1'b0;
            r_error  <= 1'b0;
            r_clk_oe <= 1'b0;
            r_dat_oe <= 1'b0;
        end else begin
            r_done  <= 1'b0;
            r_error <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_ready <= ~(tx_valid & r_ready);
                    if (tx_valid && r_ready) begin
                        r_data   <= tx_data;
                        r_parity <= ~^tx_data;
                        r_cnt    <= '0;
                        r_idx    <= '0;
                        r_clk_oe <= 1'b1;
                        r_state  <= INHIBIT;
                    end
                end
                INHIBIT: begin
                    if (w_inhibit_end) begin
                        r_dat_oe <= 1'b1;
                        r_state  <= START;
                    end else r_cnt <= r_cnt + 1'b1;
                end
                START: begin
                    r_clk_oe <= 1'b0;
                    r_cnt    <= '0;
                    r_idx    <= '0;
                    r_state  <= SHIFT;
                end
                default: begin
                    if (w_timeout) begin
                        r_clk_oe <= 1'b0;
                        r_dat_oe <= 1'b0;
                        r_error  <= 1'b1;
                        r_state  <= IDLE;
                    end else begin
                        r_cnt <= w_clk_fall ? '0 : r_cnt + 1'b1;
                        case (r_state)
                            SHIFT: if (w_clk_fall) begin
                                r_dat_oe <= ~w_frame[r_idx];
                                r_idx    <= r_idx + 1'b1;
                                if (r_idx == 4'(FRAME_BITS - 1)) r_state <= ACK;
                            end
                            ACK: if (w_clk_fall) begin
                                r_ackbad <= w_dat_sync;
                                r_state  <= WAIT_IDLE;
                            end
                            WAIT_IDLE: if (w_clk_sync && w_dat_sync) begin
                                r_done  <= ~r_ackbad;
                                r_error <= r_ackbad;
                                r_state <= IDLE;
                            end
                            default: ;
                        endcase
                    end
                end
            endcase
        end
    end

    assign tx_ready   = r_ready;
    assign tx_done    = r_done;
    assign tx_error   = r_error;
    assign ps2_clk_oe = r_clk_oe;
    assign ps2_dat_oe = r_dat_oe;
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed bench with an open-drain bus and a PS/2 device model
module tb_ps2_host_tx;
    import ps2_pkg::*;
    localparam int INH = 5000;
    localparam int TO  = 1000;
    localparam int H   = 50;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, tx_done, tx_error;
    logic       ps2_clk_oe, ps2_dat_oe;
    logic       dev_clk = 1'b1;
    logic       dev_dat = 1'b1;
    wire        ps2_clk_in = dev_clk & ~ps2_clk_oe;
    wire        ps2_dat_in = dev_dat & ~ps2_dat_oe;

    int errors = 0;
    int checks = 0;
    int done_cnt = 0, err_cnt = 0, both_cnt = 0;
    int cur_run = 0, last_run = 0;
    int d0, e0, n;
    logic [9:0] got;

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
        .CLOCK_50  (clk),
        .RESET     (rst),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .tx_done   (tx_done),
        .tx_error  (tx_error),
        .ps2_clk_in(ps2_clk_in),
        .ps2_dat_in(ps2_dat_in),
        .ps2_clk_oe(ps2_clk_oe),
        .ps2_dat_oe(ps2_dat_oe)
    );

    always #5 clk = ~clk;

    // pulse counters and length of the most recent clock-inhibit run
    always @(negedge clk) begin
        if (tx_done === 1'b1) done_cnt <= done_cnt + 1;
        if (tx_error === 1'b1) err_cnt <= err_cnt + 1;
        if (tx_done === 1'b1 && tx_error === 1'b1) both_cnt <= both_cnt + 1;
        if (ps2_clk_oe === 1'b1) cur_run <= cur_run + 1;
        else if (cur_run != 0) begin
            last_run <= cur_run;
            cur_run  <= 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic request(input logic [7:0] d);
        int k;
        tx_data  = d;
        tx_valid = 1'b1;
        k = 0;
        while (tx_ready !== 1'b1 && k < 100) begin
            @(negedge clk);
            k++;
        end
        d0 = done_cnt;
        e0 = err_cnt;
        @(negedge clk);
        tx_valid = 1'b0;
        chk("accept_clk_oe", ps2_clk_oe, 1);
        chk("accept_ready", tx_ready, 0);
    endtask

    // device: waits for request-to-send, clocks nbits, then an ack clock when nbits==10
    task automatic device(input int nbits, input logic ack, output logic [9:0] g);
        int k;
        g = '0;
        k = 0;
        while (!(ps2_clk_oe === 1'b0 && ps2_dat_oe === 1'b1) && k < 8000) begin
            @(negedge clk);
            k++;
        end
        chk("rts_seen", k < 8000, 1);
        for (int i = 0; i < nbits; i++) begin
            repeat (H) @(negedge clk);
            dev_clk = 1'b0;
            tx_data = tx_data + 8'h35;
            repeat (H) @(negedge clk);
            dev_clk = 1'b1;
            g[i] = ps2_dat_in;
        end
        if (nbits == 10) begin
            repeat (H / 2) @(negedge clk);
            dev_dat = ack;
            repeat (H / 2) @(negedge clk);
            dev_clk = 1'b0;
            repeat (H) @(negedge clk);
            dev_clk = 1'b1;
            dev_dat = 1'b1;
        end
    endtask

    task automatic wait_end(output int cnt);
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!(tx_done === 1'b1 || tx_error === 1'b1) && cnt < 3000);
    endtask

    task automatic end_check(input string tag, input logic exp_done, input int exp_n);
        int k;
        wait_end(k);
        chk({tag, "_latency"}, k, exp_n);
        chk({tag, "_done"}, tx_done, exp_done);
        chk({tag, "_error"}, tx_error, !exp_done);
        chk({tag, "_ready_at_pulse"}, tx_ready, 0);
        chk({tag, "_clk_oe"}, ps2_clk_oe, 0);
        chk({tag, "_dat_oe"}, ps2_dat_oe, 0);
        @(negedge clk);
        chk({tag, "_ready_after"}, tx_ready, 1);
        chk({tag, "_pulse_width"}, {tx_done, tx_error}, 0);
        chk({tag, "_done_count"}, done_cnt - d0, exp_done);
        chk({tag, "_error_count"}, err_cnt - e0, !exp_done);
    endtask

    initial begin
        @(negedge clk);
        chk("rst_ready", tx_ready, 1);
        chk("rst_done", tx_done, 0);
        chk("rst_error", tx_error, 0);
        chk("rst_clk_oe", ps2_clk_oe, 0);
        chk("rst_dat_oe", ps2_dat_oe, 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        request(PS2_CMD_SET_LEDS);
        device(10, 1'b0, got);
        chk("inhibit_len", last_run, INH);
        chk("frame_ed", got, 10'b11_1110_1101);
        end_check("ed", 1'b1, 3);

        request(8'h00);
        device(10, 1'b0, got);
        chk("frame_00", got, 10'b11_0000_0000);
        end_check("b00", 1'b1, 3);

        request(8'h01);
        device(10, 1'b0, got);
        chk("frame_01", got, 10'b10_0000_0001);
        end_check("b01", 1'b1, 3);

        request(PS2_CMD_ECHO);
        device(10, 1'b1, got);
        chk("frame_ee", got, 10'b11_1110_1110);
        end_check("nack", 1'b0, 3);

        request(8'hF0);
        device(4, 1'b0, got);
        chk("stall_bits", got[3:0], 4'b0000);
        chk("stall_dat_held", ps2_dat_oe, 1);
        end_check("timeout", 1'b0, TO - H + 3);

        request(8'h00);
        device(6, 1'b0, got);
        chk("bit5_driven", ps2_dat_oe, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_clk_oe", ps2_clk_oe, 0);
        chk("midrst_dat_oe", ps2_dat_oe, 0);
        chk("midrst_ready", tx_ready, 1);
        repeat (TO + 100) @(negedge clk);
        chk("midrst_no_done", done_cnt - d0, 0);
        chk("midrst_no_error", err_cnt - e0, 0);

        request(PS2_CMD_RESET);
        device(10, 1'b0, got);
        chk("frame_ff", got, 10'b11_1111_1111);
        end_check("ff", 1'b1, 3);

        tx_data  = 8'h3C;
        tx_valid = 1'b1;
        d0 = done_cnt;
        e0 = err_cnt;
        @(negedge clk);
        chk("held_accept_clk_oe", ps2_clk_oe, 1);
        chk("held_accept_ready", tx_ready, 0);
        device(10, 1'b0, got);
        chk("frame_3c", got, 10'b11_0011_1100);
        wait_end(n);
        chk("held_done", tx_done, 1);
        tx_data = 8'hA5;
        @(negedge clk);
        chk("held_ready_rise", tx_ready, 1);
        chk("held_done_count", done_cnt - d0, 1);
        d0 = done_cnt;
        e0 = err_cnt;
        @(negedge clk);
        chk("b2b_accept_ready", tx_ready, 0);
        chk("b2b_accept_clk_oe", ps2_clk_oe, 1);
        tx_valid = 1'b0;
        device(10, 1'b0, got);
        chk("frame_a5", got, 10'b11_1010_0101);
        end_check("a5", 1'b1, 3);

        chk("never_both", both_cnt, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
